// File: rtl/flash_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : flash_rd_ctrl
//  Description : Wishbone slave that reads an 8-bit parallel NOR flash for the
//                boot ROM / BIOS window. Each Wishbone access is built from one
//                or two flash byte reads of WAIT+1 cycles each. A direct low
//                region is reached with wb_tga_i=0; wb_tga_i=1 selects a
//                paged window whose page comes from a writable base register.
//                Optional feature macro: FLASH_CACHE_EN (one-word read cache).
//  Revision    : 1.0 - initial release
// ============================================================================
module flash_rd_ctrl #(
    parameter int ADDR_W = 22,
    parameter int BASE_W = 12,
    parameter int WIN_W  = 8,
    parameter int WAIT   = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [15:0]       wb_dat_i,
    output logic [15:0]       wb_dat_o,
    input  logic [16:1]       wb_adr_i,
    input  logic              wb_we_i,
    input  logic              wb_tga_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic [1:0]        wb_sel_i,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] flash_addr_,
    input  logic [7:0]        flash_data_,
    output logic              flash_we_n_,
    output logic              flash_oe_n_,
    output logic              flash_ce_n_,
    output logic              flash_rst_n_
);

    // Word-address width (flash byte address without bit 0)
    localparam int         C_AW1  = ADDR_W - 1;
    localparam logic [3:0] C_WAIT = 4'(WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_B0   = 2'd1,
        ST_B1   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [BASE_W-1:0]   r_base;
    logic [BASE_W-1:0]   w_base_nxt;
    logic [15:0]         r_dat;
    logic [15:0]         w_dat_nxt;
    logic [7:0]          r_lo;
    logic [7:0]          w_lo_nxt;
    logic                r_ack;

    logic                w_op;
    logic                w_byte_done;
    logic                w_busy;
    logic                w_addr0;
    logic [C_AW1-1:0]    w_word_addr;

    // Cache hooks (tied off when the cache is not built)
    logic                w_hit;
    logic [15:0]         w_hit_dat;
    logic                w_fill;
    logic                w_clear;

    assign w_op        = wb_stb_i & wb_cyc_i;
    assign w_byte_done = (r_cnt == C_WAIT);
    assign w_busy      = (r_state == ST_B0) || (r_state == ST_B1);

    // Window mode forms {1, page, offset}; direct mode zero-extends the word address
    assign w_word_addr = wb_tga_i ? {1'b1, r_base, wb_adr_i[WIN_W:1]}
                                  : C_AW1'(wb_adr_i);

    // Odd byte is fetched for the high half of a word or a high-lane-only read
    assign w_addr0 = (r_state == ST_B1) ||
                     ((r_state == ST_B0) && (wb_sel_i == 2'b10));

    // State, counter, base, data and ack registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_base  <= '0;
            r_dat   <= 16'h0000;
            r_lo    <= 8'h00;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_base  <= w_base_nxt;
            r_dat   <= w_dat_nxt;
            r_lo    <= w_lo_nxt;
            r_ack   <= (w_state_nxt == ST_ACK);
        end
    end

    // Next-state, wait counting and byte assembly
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_base_nxt  = r_base;
        w_dat_nxt   = r_dat;
        w_lo_nxt    = r_lo;
        w_fill      = 1'b0;
        w_clear     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = 4'd0;
                if (w_op) begin
                    if (wb_we_i) begin
                        // Only the base register is writable; flash writes are dropped
                        if (wb_tga_i) begin
                            w_base_nxt = wb_dat_i[BASE_W-1:0];
                            w_clear    = 1'b1;
                        end
                        w_state_nxt = ST_ACK;
                    end else if (wb_sel_i == 2'b00) begin
                        w_dat_nxt   = 16'h0000;
                        w_state_nxt = ST_ACK;
                    end else if (w_hit) begin
                        w_dat_nxt   = w_hit_dat;
                        w_state_nxt = ST_ACK;
                    end else begin
                        w_state_nxt = ST_B0;
                    end
                end
            end

            ST_B0: begin
                if (!w_op) begin
                    // Master abandoned the cycle: drop it without touching wb_dat_o
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (w_byte_done) begin
                    w_cnt_nxt = 4'd0;
                    case (wb_sel_i)
                        2'b11: begin
                            // Low byte is held aside so an abort in B1 leaves wb_dat_o intact
                            w_lo_nxt    = flash_data_;
                            w_state_nxt = ST_B1;
                        end
                        2'b01: begin
                            w_dat_nxt   = {8'h00, flash_data_};
                            w_state_nxt = ST_ACK;
                        end
                        2'b10: begin
                            w_dat_nxt   = {flash_data_, 8'h00};
                            w_state_nxt = ST_ACK;
                        end
                        default: begin
                            w_dat_nxt   = 16'h0000;
                            w_state_nxt = ST_ACK;
                        end
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            ST_B1: begin
                if (!w_op) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end else if (w_byte_done) begin
                    w_cnt_nxt   = 4'd0;
                    w_dat_nxt   = {flash_data_, r_lo};
                    w_fill      = 1'b1;
                    w_state_nxt = ST_ACK;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end

            ST_ACK: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_cnt_nxt   = 4'd0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef FLASH_CACHE_EN
    logic             r_cvalid;
    logic [C_AW1-1:0] r_ctag;
    logic [15:0]      r_cdat;

    // One-entry word cache: filled by completed word reads, flushed by base writes
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cvalid <= 1'b0;
            r_ctag   <= '0;
            r_cdat   <= 16'h0000;
        end else if (w_clear) begin
            r_cvalid <= 1'b0;
        end else if (w_fill) begin
            r_cvalid <= 1'b1;
            r_ctag   <= w_word_addr;
            r_cdat   <= {flash_data_, r_lo};
        end
    end

    assign w_hit = r_cvalid && (r_ctag == w_word_addr);

    // Cached word masked down to the requested byte lanes
    always_comb begin
        w_hit_dat = r_cdat;
        case (wb_sel_i)
            2'b01:   w_hit_dat = {8'h00, r_cdat[7:0]};
            2'b10:   w_hit_dat = {r_cdat[15:8], 8'h00};
            2'b11:   w_hit_dat = r_cdat;
            default: w_hit_dat = 16'h0000;
        endcase
    end
`else
    logic w_unused_cache;

    assign w_hit          = 1'b0;
    assign w_hit_dat      = 16'h0000;
    assign w_unused_cache = ^{w_fill, w_clear};
`endif

    generate
        if (BASE_W < 16) begin : g_dat_unused
            logic w_unused_dat;
            assign w_unused_dat = ^wb_dat_i[15:BASE_W];
        end
    endgenerate

    assign wb_ack_o     = r_ack;
    assign wb_dat_o     = r_dat;
    assign flash_addr_  = {w_word_addr, w_addr0};
    assign flash_oe_n_  = ~w_busy;
    assign flash_ce_n_  = ~w_busy;
    assign flash_we_n_  = 1'b1;
    assign flash_rst_n_ = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_flash_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_flash_rd_ctrl
//  Description : Scoreboard bench for flash_rd_ctrl. One instance with WAIT=1
//                and one with WAIT=3 share the Wishbone bus; stb is steered to
//                one of them at a time. Expected acks are queued at issue time
//                and checked by a monitor on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_rd_ctrl;

`ifdef FLASH_CACHE_EN
    localparam bit C_CACHE = 1'b1;
`else
    localparam bit C_CACHE = 1'b0;
`endif

    typedef struct {
        logic [15:0] dat;
        bit          chk_dat;
        int          cyc;
        int          tag;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] wdat;
    logic [16:1] adr;
    logic        we;
    logic        tga;
    logic        stb;
    logic        cyc_i;
    logic [1:0]  sel;
    int          dsel;

    logic        stb1, stb3;
    logic [15:0] dat1, dat3;
    logic        ack1, ack3;
    logic [21:0] fa1, fa3;
    logic [7:0]  fd1, fd3;
    logic        we_n1, oe_n1, ce_n1, rst_n1;
    logic        we_n3, oe_n3, ce_n3, rst_n3;

    logic [7:0]  mem [logic [21:0]];
    exp_t        q1[$];
    exp_t        q3[$];

    int          cyc;
    int          checks;
    int          errors;
    int          oe_cnt;
    int          first_oe;
    logic [21:0] first_addr;
    logic [21:0] last_addr;

    assign stb1 = stb & (dsel == 0);
    assign stb3 = stb & (dsel == 1);

    flash_rd_ctrl #(.ADDR_W(22), .BASE_W(12), .WIN_W(8), .WAIT(1)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wdat), .wb_dat_o(dat1),
        .wb_adr_i(adr), .wb_we_i(we), .wb_tga_i(tga), .wb_stb_i(stb1),
        .wb_cyc_i(cyc_i), .wb_sel_i(sel), .wb_ack_o(ack1),
        .flash_addr_(fa1), .flash_data_(fd1), .flash_we_n_(we_n1),
        .flash_oe_n_(oe_n1), .flash_ce_n_(ce_n1), .flash_rst_n_(rst_n1)
    );

    flash_rd_ctrl #(.ADDR_W(22), .BASE_W(12), .WIN_W(8), .WAIT(3)) u_dut_w3 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wdat), .wb_dat_o(dat3),
        .wb_adr_i(adr), .wb_we_i(we), .wb_tga_i(tga), .wb_stb_i(stb3),
        .wb_cyc_i(cyc_i), .wb_sel_i(sel), .wb_ack_o(ack3),
        .flash_addr_(fa3), .flash_data_(fd3), .flash_we_n_(we_n3),
        .flash_oe_n_(oe_n3), .flash_ce_n_(ce_n3), .flash_rst_n_(rst_n3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Erased flash reads 0xFF except where the bench has placed a byte
    function automatic logic [7:0] model(input logic [21:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'hFF;
    endfunction

    // Flash data follows the address presented during the current cycle
    always @(negedge clk) begin
        fd1 = model(fa1);
        fd3 = model(fa3);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_ack(input int d, input logic [15:0] act);
        exp_t e;
        int   n;
        n = (d == 0) ? q1.size() : q3.size();
        if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack dut%0d: got ack with data %h, expected none (cycle %0d)", d, act, cyc);
        end else begin
            if (d == 0) e = q1.pop_front();
            else        e = q3.pop_front();
            checks++;
            if (cyc != e.cyc) begin
                errors++;
                $display("FAIL ack_cycle tag%0d: got cycle %0d expected %0d", e.tag, cyc, e.cyc);
            end
            if (e.chk_dat) begin
                checks++;
                if (act !== e.dat) begin
                    errors++;
                    $display("FAIL ack_data tag%0d: got %h expected %h", e.tag, act, e.dat);
                end
            end
        end
    endtask

    // Monitor: every ack is matched against the oldest expectation for that DUT
    always @(negedge clk) begin
        if (ack1) check_ack(0, dat1);
        if (ack3) check_ack(1, dat3);
    end

    // Issue one access, queue its expected ack, and wait (bounded) for the ack
    task automatic wb_op(input int d, input bit w, input bit t, input logic [15:0] a,
                         input logic [1:0] s, input logic [15:0] wd,
                         input logic [15:0] exp_dat, input bit chk_dat,
                         input int lat, input int tag);
        exp_t        e;
        int          start;
        bit          got;
        logic        o;
        logic [21:0] fa;
        @(posedge clk);
        #1;
        dsel  = d;
        we    = w;
        tga   = t;
        adr   = a;
        sel   = s;
        wdat  = wd;
        stb   = 1'b1;
        cyc_i = 1'b1;
        start = cyc;
        e = '{exp_dat, chk_dat, start + lat, tag};
        if (d == 0) q1.push_back(e);
        else        q3.push_back(e);
        oe_cnt     = 0;
        first_oe   = -1;
        first_addr = '0;
        last_addr  = '0;
        got        = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            o  = (d == 0) ? oe_n1 : oe_n3;
            fa = (d == 0) ? fa1 : fa3;
            if (!o) begin
                if (first_oe < 0) begin
                    first_oe   = cyc - start;
                    first_addr = fa;
                end
                last_addr = fa;
                oe_cnt++;
            end
            if (((d == 0) ? ack1 : ack3) == 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL timeout tag%0d: got no ack within 64 cycles, expected ack at cycle %0d", tag, start + lat);
            if (d == 0) void'(q1.pop_back());
            else        void'(q3.pop_back());
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        stb   = 1'b0;
        cyc_i = 1'b0;
        we    = 1'b0;
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        stb    = 1'b0;
        cyc_i  = 1'b0;
        we     = 1'b0;
        tga    = 1'b0;
        adr    = '0;
        sel    = 2'b00;
        wdat   = 16'h0000;
        dsel   = 0;
        fd1    = 8'hFF;
        fd3    = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack",   {31'd0, ack1},  32'h0);
        chk("rst_dat",   {16'd0, dat1},  32'h0);
        chk("rst_oe_n",  {31'd0, oe_n1}, 32'h1);
        chk("rst_ce_n",  {31'd0, ce_n1}, 32'h1);
        chk("we_n_tied", {31'd0, we_n1}, 32'h1);
        chk("rst_n_tied",{31'd0, rst_n1},32'h1);
        chk("rst_oe_n3", {31'd0, oe_n3}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-lane reads at word 0x0010 (bytes 0x20/0x21)
        mem[22'h000020] = 8'hCD;
        mem[22'h000021] = 8'hAB;
        mem[22'h35780A] = 8'h5A;
        mem[22'h35780B] = 8'hC3;
        wb_op(0, 0, 0, 16'h0010, 2'b10, 16'h0, 16'hAB00, 1, 3, 1);
        chk("sel10_oe_cycles", oe_cnt, 2);
        chk("sel10_addr", first_addr, 22'h000021);
        idle();
        wb_op(0, 0, 0, 16'h0010, 2'b01, 16'h0, 16'h00CD, 1, 3, 2);
        chk("sel01_addr", first_addr, 22'h000020);
        idle();

        // Word read: oe low in cycles 1..4, ack in cycle 5
        mem[22'h000020] = 8'h34;
        mem[22'h000021] = 8'h12;
        wb_op(0, 0, 0, 16'h0010, 2'b11, 16'h0, 16'h1234, 1, 5, 3);
        chk("word_oe_cycles", oe_cnt, 4);
        chk("word_oe_first",  first_oe, 1);
        chk("word_addr_lo",   first_addr, 22'h000020);
        chk("word_addr_hi",   last_addr,  22'h000021);
        idle();

        // Repeat of the same word, then masked lanes (cache hits when built)
        wb_op(0, 0, 0, 16'h0010, 2'b11, 16'h0, 16'h1234, 1, C_CACHE ? 1 : 5, 4);
        chk("repeat_oe_cycles", oe_cnt, C_CACHE ? 0 : 4);
        wb_op(0, 0, 0, 16'h0010, 2'b01, 16'h0, 16'h0034, 1, C_CACHE ? 1 : 3, 5);
        wb_op(0, 0, 0, 16'h0010, 2'b00, 16'h0, 16'h0000, 1, 1, 6);
        chk("sel00_no_flash", oe_cnt, 0);

        // Direct-region write is dropped; base stays 0
        wb_op(0, 1, 0, 16'h0005, 2'b11, 16'hFFFF, 16'h0, 0, 1, 7);
        idle();
        wb_op(0, 0, 1, 16'h0005, 2'b11, 16'h0, 16'hFFFF, 1, 5, 8);
        chk("win_base0_lo", first_addr, 22'h20000A);
        chk("win_base0_hi", last_addr,  22'h20000B);

        // Base write, then back-to-back reads using it
        wb_op(0, 1, 1, 16'h0000, 2'b11, 16'h0ABC, 16'h0, 0, 1, 9);
        wb_op(0, 0, 0, 16'h0010, 2'b11, 16'h0, 16'h1234, 1, 5, 10);
        wb_op(0, 0, 1, 16'hFF05, 2'b11, 16'h0, 16'hC35A, 1, 5, 11);
        chk("win_abc_lo", first_addr, 22'h35780A);
        chk("win_abc_hi", last_addr,  22'h35780B);
        idle();

        // Reset during B1 of a word read (B0 = cycles 1-2, B1 = cycles 3-4)
        @(posedge clk);
        #1;
        dsel = 0; we = 1'b0; tga = 1'b0; adr = 16'h0010; sel = 2'b11;
        stb = 1'b1; cyc_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("b1_oe_low", {31'd0, oe_n1}, 32'h0);
        @(negedge clk);
        chk("midrst_ack",  {31'd0, ack1},  32'h0);
        chk("midrst_oe_n", {31'd0, oe_n1}, 32'h1);
        chk("midrst_ce_n", {31'd0, ce_n1}, 32'h1);
        chk("midrst_dat",  {16'd0, dat1},  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stb = 1'b0;
        cyc_i = 1'b0;
        wb_op(0, 0, 1, 16'h0005, 2'b11, 16'h0, 16'hFFFF, 1, 5, 12);
        chk("midrst_base0", first_addr, 22'h20000A);
        idle();

        // WAIT=3: cyc drops in cycle 3 of a word read (still in B0)
        @(posedge clk);
        #1;
        dsel = 1; we = 1'b0; tga = 1'b0; adr = 16'h0010; sel = 2'b11;
        stb = 1'b1; cyc_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cyc_i = 1'b0;
        @(negedge clk);
        chk("w3_oe_low_c3", {31'd0, oe_n3}, 32'h0);
        @(negedge clk);
        chk("abort_oe_n", {31'd0, oe_n3}, 32'h1);
        chk("abort_ack",  {31'd0, ack3},  32'h0);
        chk("abort_dat",  {16'd0, dat3},  32'h0);
        repeat (8) @(negedge clk);
        stb = 1'b0;
        wb_op(1, 0, 0, 16'h0010, 2'b11, 16'h0, 16'h1234, 1, 9, 13);
        chk("w3_word_oe_cycles", oe_cnt, 8);
        idle();
        wb_op(1, 0, 0, 16'h0010, 2'b10, 16'h0, 16'h1200, 1, C_CACHE ? 1 : 5, 14);
        idle();

        repeat (5) @(negedge clk);
        chk("q1_drained", q1.size(), 0);
        chk("q3_drained", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flash_rd_ctrl.md
Name: flash_rd_ctrl

Overview:
- Parametrised Wishbone slave that reads an 8-bit parallel NOR flash for the boot ROM and BIOS window.
- Each Wishbone access is assembled from one or two flash byte reads, with a programmable number of wait cycles per byte.
- Supports a direct low region and a paged window selected by a writable base register (wb_tga_i).
- Registered ack and data, abort on cyc drop, and an optional one-word read cache.

Parameters:
ADDR_W, 22, flash byte-address width; must equal 2 + BASE_W + WIN_W and be at least 17
BASE_W, 12, width of the page base register
WIN_W, 8, word-offset bits taken from wb_adr_i in window mode (wb_adr_i[WIN_W:1])
WAIT, 1, extra hold cycles per flash byte access (0..15); each byte read lasts WAIT+1 cycles

Ports:
wb_clk_i  in  1  clock; all state changes on its rising edge
wb_rst_i  in  1  reset, synchronous, active-high
wb_dat_i  in  16  write data; bits [BASE_W-1:0] load base
wb_dat_o  out  16  registered read data
wb_adr_i  in  16  word address, bits [16:1]
wb_we_i  in  1  write enable
wb_tga_i  in  1  1 = window/base-register access
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_sel_i  in  2  byte lane select
wb_ack_o  out  1  registered single-cycle acknowledge
flash_addr_  out  ADDR_W  flash byte address
flash_data_  in  8  flash data bus
flash_we_n_  out  1  tied 1
flash_oe_n_  out  1  output enable, active low
flash_ce_n_  out  1  chip enable, active low
flash_rst_n_  out  1  tied 1

Behaviour:
- op = wb_stb_i & wb_cyc_i. States: IDLE, B0 (first/only byte), B1 (high byte of word), ACK. A 4-bit counter cnt is used in B0/B1.
- Reset: state IDLE, cnt 0, base 0, wb_ack_o 0, wb_dat_o 0, flash_oe_n_/flash_ce_n_ 1. Reset wins over every other event, including mid-operation.
- IDLE with op:
  - Write (wb_we_i=1): if wb_tga_i, base <= wb_dat_i[BASE_W-1:0]; if not wb_tga_i, the write is ignored (flash not writable). Go to ACK in either case.
  - Read with wb_sel_i=00: wb_dat_o <= 0; go to ACK.
  - Any other read: go to B0 with cnt=0.
- B0/B1:
  - flash_oe_n_ = flash_ce_n_ = 0.
  - cnt increments each cycle. When cnt==WAIT, sample flash_data_ and reset cnt.
  - B0 with wb_sel_i=11: byte goes to low half of wb_dat_o; go to B1.
  - B0 with wb_sel_i=01: wb_dat_o <= {8'h00, byte}; go to ACK.
  - B0 with wb_sel_i=10: wb_dat_o <= {byte, 8'h00}; go to ACK.
  - B1: byte goes to high half; go to ACK.
- ACK: wb_ack_o=1 for exactly this cycle; next state IDLE. flash_oe_n_/flash_ce_n_ are 1 in IDLE and ACK.
- Latency, with op first seen in IDLE in cycle 0:
  - write or sel=00: ack in cycle 1
  - byte read: ack in cycle WAIT+2
  - word read: ack in cycle 2*WAIT+3
  - back-to-back ops: a new op starts in the cycle after ACK.
- Abort: op deasserts while in B0/B1 -> IDLE next cycle, no ack, wb_dat_o unchanged.
- Address:
  - flash_addr_[ADDR_W-1:1] = wb_tga_i ? {1'b1, base, wb_adr_i[WIN_W:1]} : zero-extended wb_adr_i[16:1].
  - flash_addr_[0] = 1 in B1, or in B0 when wb_sel_i=10; otherwise 0.
  - The master holds wb_adr_i/wb_sel_i/wb_tga_i stable until ack, per Wishbone.
- A base write takes effect for window reads starting in the cycle after its ACK.

Optional Feature:
- FLASH_CACHE_EN defined:
  - One-entry cache: valid bit, tag of ADDR_W-1 bits (word address), 16-bit data.
  - Every completed word read (sel=11) fills the entry.
  - A read in IDLE whose computed word address matches a valid tag goes straight to ACK (ack in cycle 1). Returned data is masked by sel: 01 -> {00, lo}; 10 -> {hi, 00}; 11 -> full word. The flash is not accessed.
  - Base write or reset clears valid. An aborted access does not fill the entry.
- FLASH_CACHE_EN undefined: no cache logic; every read accesses the flash.

Test Plan:
- WAIT=1, direct word read at wb_adr_i=16'h0010, flash returns 8'h34 at byte address 0x20 and 8'h12 at 0x21 -> ack in cycle 5, wb_dat_o=16'h1234, oe_n low in cycles 1-4 only.
- sel=10 read at 16'h0010, flash byte 8'hAB at 0x21 -> ack in cycle 3, wb_dat_o=16'hAB00; sel=01 with 8'hCD at 0x20 -> 16'h00CD.
- tga write with wb_dat_i=16'h0ABC, then tga word read at wb_adr_i[8:1]=8'h05 -> ack cycle 1 for the write; flash_addr_ = {1'b1, 12'hABC, 8'h05, addr0} with addr0 = 0 then 1.
- WAIT=3, cyc drops in cycle 3 of a word read -> no ack, state IDLE in cycle 4, next read completes normally with ack in cycle 9.
- Reset asserted mid-B1 -> next cycle ack=0, oe_n/ce_n=1, base=0, wb_dat_o=0.
- FLASH_CACHE_EN: repeat the same word read -> second ack in cycle 1 with identical data and oe_n stays 1; after a base write, the same read takes the full flash latency again.
